// File: rtl/key_input_array.sv
// Multi-channel key front end: polarity normalise, 2-flop synchronise, sampled debounce,
// press/release edge pulses and optional auto-repeat. The auto-repeat strobe is exported
// as repeat_pulse because "repeat" is a reserved word.
module key_input_array #(
    parameter int unsigned CHANNELS            = 8,
    parameter int unsigned CLOCK_HZ            = 12_000_000,
    parameter int unsigned SAMPLE_HZ           = 10_000,
    parameter int unsigned FILTER_COUNT        = 3,
    parameter int unsigned ACTIVE_LOW          = 1,
    parameter int unsigned REPEAT_DELAY_TICKS  = 5000,
    parameter int unsigned REPEAT_PERIOD_TICKS = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] keys_async,
    input  logic                bypass,
    input  logic                repeat_enable,
    output logic [CHANNELS-1:0] key_state,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int unsigned DIV = CLOCK_HZ / SAMPLE_HZ;
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CW  = (FILTER_COUNT > 0) ? $clog2(FILTER_COUNT + 1) : 1;
    localparam int unsigned RW  = $clog2(REPEAT_DELAY_TICKS + 1);

    localparam logic [DW-1:0] DIV_ONE     = DW'(1);
    localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] CNT_LAST    = CW'(FILTER_COUNT);
    localparam logic [RW-1:0] RCNT_ONE    = RW'(1);
    localparam logic [RW-1:0] RCNT_FIRE   = RW'(REPEAT_DELAY_TICKS);
    localparam logic [RW-1:0] RCNT_RELOAD = RW'(REPEAT_DELAY_TICKS - REPEAT_PERIOD_TICKS);

    logic [CHANNELS-1:0] raw;
    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;
    logic [CHANNELS-1:0] filt;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] repeat_q;
    logic [CW-1:0]       cnt  [CHANNELS];
    logic [RW-1:0]       rcnt [CHANNELS];
    logic [DW-1:0]       div_cnt;
    logic                tick;

    assign raw  = (ACTIVE_LOW != 0) ? ~keys_async : keys_async;
    assign tick = (div_cnt == DIV_LAST);

    // Two-flop synchroniser on the normalised (1 = pressed) pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Shared sample-rate prescaler; tick marks the last cycle of each sample period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // Debounce: filt flips after FILTER_COUNT consecutive differing samples; bypass tracks sync.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= '0;
            end
        end else if (bypass) begin
            // Keep filt aligned so that leaving bypass produces no edge.
            filt <= sync_b;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (sync_b[i] != filt[i]) begin
                    if (cnt[i] + CNT_ONE == CNT_LAST) begin
                        filt[i] <= ~filt[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_ONE;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign key_state = bypass ? sync_b : filt;

    // Previous debounced level for edge decoding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= key_state;
        end
    end

    assign pressed  = key_state & ~prev;
    assign released = ~key_state & prev;

    // Auto-repeat: count held ticks, fire at the delay, then reload for the period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            repeat_q <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                rcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                repeat_q[i] <= 1'b0;
                if (!key_state[i] || !repeat_enable) begin
                    rcnt[i] <= '0;
                end else if (tick) begin
                    if (rcnt[i] + RCNT_ONE == RCNT_FIRE) begin
                        repeat_q[i] <= 1'b1;
                        rcnt[i]     <= RCNT_RELOAD;
                    end else begin
                        rcnt[i] <= rcnt[i] + RCNT_ONE;
                    end
                end
            end
        end
    end

    assign repeat_pulse = repeat_q;

endmodule

// File: tb/tb_key_input_array.sv
// Randomised and directed bench for key_input_array against a sample-history model.
module tb_key_input_array;

    localparam int unsigned CH  = 4;
    localparam int unsigned FC  = 3;
    localparam int unsigned DLY = 5;
    localparam int unsigned PER = 2;
    localparam int          DIV = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CH-1:0] keys_async;
    logic          bypass;
    logic          repeat_enable;
    logic [CH-1:0] key_state;
    logic [CH-1:0] pressed;
    logic [CH-1:0] released;
    logic [CH-1:0] repeat_pulse;

    key_input_array #(
        .CHANNELS            (CH),
        .CLOCK_HZ            (1000),
        .SAMPLE_HZ           (100),
        .FILTER_COUNT        (FC),
        .ACTIVE_LOW          (1),
        .REPEAT_DELAY_TICKS  (DLY),
        .REPEAT_PERIOD_TICKS (PER)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .keys_async    (keys_async),
        .bypass        (bypass),
        .repeat_enable (repeat_enable),
        .key_state     (key_state),
        .pressed       (pressed),
        .released      (released),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clock = ~clock;

    // Stimulus state
    logic [CH-1:0] pins;
    bit            byp;
    bit            ren;
    bit            rst_drv;

    // Reference model: cycles since reset, raw pin history, tick sample history per channel
    int            m_cyc;
    logic [CH-1:0] m_h1;
    logic [CH-1:0] m_h2;
    logic [CH-1:0] m_filt;
    logic [CH-1:0] m_prev;
    logic [CH-1:0] m_rep;
    int            samp [CH][FC];
    int            held [CH];

    // Event tallies observed on the DUT
    int cyc_abs;
    int n_press [CH];
    int n_rel [CH];
    int n_rep [CH];
    int first_press [CH];
    int first_rep [CH];
    bit saw_1001;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_abs);
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_h1   = '0;
        m_h2   = '0;
        m_filt = '0;
        m_prev = '0;
        m_rep  = '0;
        for (int i = 0; i < int'(CH); i++) begin
            held[i] = 0;
            for (int j = 0; j < int'(FC); j++) samp[i][j] = 2;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < int'(CH); i++) begin
            n_press[i]     = 0;
            n_rel[i]       = 0;
            n_rep[i]       = 0;
            first_press[i] = -1;
            first_rep[i]   = -1;
        end
        saw_1001 = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cycle();
        logic [CH-1:0] sync, key, exp_p, exp_r, next_filt;
        bit            tick, all_diff;
        @(negedge clock);
        keys_async    = pins;
        bypass        = byp;
        repeat_enable = ren;
        reset_n       = rst_drv;
        #1;
        if (!rst_drv) model_reset();
        sync  = m_h2;
        key   = byp ? sync : m_filt;
        exp_p = key & ~m_prev;
        exp_r = ~key & m_prev;
        check("outputs", {16'h0, key_state, pressed, released, repeat_pulse},
              {16'h0, key, exp_p, exp_r, m_rep});
        for (int i = 0; i < int'(CH); i++) begin
            if (pressed[i] === 1'b1) begin
                if (n_press[i] == 0) first_press[i] = cyc_abs;
                n_press[i]++;
            end
            if (released[i] === 1'b1) n_rel[i]++;
            if (repeat_pulse[i] === 1'b1) begin
                if (n_rep[i] == 0) first_rep[i] = cyc_abs;
                n_rep[i]++;
            end
        end
        if (pressed === 4'b1001) saw_1001 = 1;
        if (rst_drv) begin
            tick      = ((m_cyc % DIV) == DIV - 1);
            next_filt = m_filt;
            for (int i = 0; i < int'(CH); i++) begin
                if (byp) begin
                    for (int j = 0; j < int'(FC); j++) samp[i][j] = 2;
                    next_filt[i] = sync[i];
                end else if (tick) begin
                    for (int j = int'(FC) - 1; j > 0; j--) samp[i][j] = samp[i][j-1];
                    samp[i][0] = sync[i] ? 1 : 0;
                    all_diff = 1;
                    for (int j = 0; j < int'(FC); j++)
                        if (samp[i][j] != (m_filt[i] ? 0 : 1)) all_diff = 0;
                    if (all_diff) next_filt[i] = ~m_filt[i];
                end
            end
            m_rep = '0;
            for (int i = 0; i < int'(CH); i++) begin
                if (!key[i] || !ren) begin
                    held[i] = 0;
                end else if (tick) begin
                    held[i]++;
                    if (held[i] == int'(DLY) ||
                        (held[i] > int'(DLY) && ((held[i] - int'(DLY)) % int'(PER)) == 0))
                        m_rep[i] = 1'b1;
                end
            end
            m_filt = next_filt;
            m_prev = key;
            m_h2   = m_h1;
            m_h1   = ~pins;
            m_cyc++;
        end
        cyc_abs++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Run until the next cycle starts at the given prescaler phase.
    task automatic align(input int phase);
        while ((m_cyc % DIV) != phase) cycle();
    endtask

    task automatic bounce(input int ch, input bit start_low);
        for (int k = 0; k < 20; k++) begin
            pins[ch] = ((k % 2 == 0) == start_low) ? 1'b0 : 1'b1;
            run(5);
        end
    endtask

    int t0;
    int lat;

    initial begin
        pins    = '1;
        byp     = 0;
        ren     = 0;
        rst_drv = 0;
        cyc_abs = 0;
        model_reset();
        clear_counts();
        run(3);
        check("reset_state", {16'h0, key_state, pressed, released, repeat_pulse}, 32'h0);
        rst_drv = 1;

        // Clean press at cycle 100 after reset release
        run(100);
        clear_counts();
        pins[0] = 1'b0;
        t0 = cyc_abs;
        run(40);
        lat = first_press[0] - t0;
        check("clean_press_count", n_press[0], 1);
        check("clean_press_latency", (lat >= 21 && lat <= 32), 1);
        check("clean_other_channels", n_press[1] + n_press[2] + n_press[3], 0);
        pins[0] = 1'b1;
        run(40);
        check("clean_release_count", n_rel[0], 1);

        // Bounce press, then bounce release
        align(0);
        clear_counts();
        bounce(1, 1'b1);
        check("bounce_no_press", n_press[1], 0);
        pins[1] = 1'b0;
        t0 = cyc_abs;
        run(40);
        lat = first_press[1] - t0;
        check("bounce_press_count", n_press[1], 1);
        check("bounce_press_latency", (lat >= 21 && lat <= 32), 1);
        align(0);
        clear_counts();
        bounce(1, 1'b0);
        check("bounce_no_release", n_rel[1], 0);
        pins[1] = 1'b1;
        run(40);
        check("bounce_release_count", n_rel[1], 1);

        // Bypass: every falling pin edge is a press
        byp = 1;
        clear_counts();
        bounce(1, 1'b1);
        pins[1] = 1'b0;
        run(20);
        check("bypass_press_count", n_press[1], 11);
        check("bypass_release_count", n_rel[1], 10);
        clear_counts();
        byp = 0;
        run(30);
        check("bypass_exit_no_edge", n_press[1] + n_rel[1], 0);
        check("bypass_exit_level", key_state[1], 1);
        pins[1] = 1'b1;
        run(40);

        // Auto-repeat on key 2
        ren = 1;
        align(0);
        clear_counts();
        pins[2] = 1'b0;
        run(100);
        pins[2] = 1'b1;
        run(60);
        check("repeat_count", n_rep[2], 3);
        check("repeat_first_delay", first_rep[2] - first_press[2], 50);
        check("repeat_release_count", n_rel[2], 1);
        ren = 0;
        clear_counts();
        pins[2] = 1'b0;
        run(150);
        pins[2] = 1'b1;
        run(40);
        check("repeat_disabled", n_rep[2], 0);

        // Simultaneous press on keys 0 and 3
        clear_counts();
        pins[0] = 1'b0;
        pins[3] = 1'b0;
        run(40);
        check("simultaneous_pressed", saw_1001, 1);
        check("ks0_held", key_state[0], 1);

        // Reset mid-press
        clear_counts();
        rst_drv = 0;
        run(3);
        check("reset_mid_outputs", {16'h0, key_state, pressed, released, repeat_pulse}, 32'h0);
        check("reset_mid_no_release", n_rel[0] + n_rel[3], 0);
        rst_drv = 1;
        clear_counts();
        t0 = cyc_abs;
        run(40);
        lat = first_press[0] - t0;
        check("reset_repress_latency", (lat >= 21 && lat <= 32), 1);
        pins = '1;
        run(40);

        // Randomised traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < int'(CH); i++)
                if ($urandom_range(0, 59) == 0) pins[i] = ~pins[i];
            if ($urandom_range(0, 249) == 0) byp = ~byp;
            if ($urandom_range(0, 199) == 0) ren = ~ren;
            rst_drv = ($urandom_range(0, 999) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
